// File: rtl/ps2_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ps2_pkg
//  Description : Shared types and constants for the PS/2 keyboard receiver:
//                frame FSM state encoding, prefix/status byte values and the
//                packed key-event record stored in the event queue.
//  Revision    : 1.0 - initial release
// ============================================================================
package ps2_pkg;

   // Frame receiver states, explicit 2-bit encoding
   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_DATA   = 2'd1,
      ST_PARITY = 2'd2,
      ST_STOP   = 2'd3
   } ps2_state_e;

   // Prefix bytes folded into flags, and status bytes passed through as events
   localparam logic [7:0] PS2_EXT    = 8'hE0;
   localparam logic [7:0] PS2_REL    = 8'hF0;
   localparam logic [7:0] PS2_BAT_OK = 8'hAA;
   localparam logic [7:0] PS2_ACK    = 8'hFA;

   // One queued key event: extended flag, release flag, scan code
   typedef struct packed {
      logic       ext;
      logic       rel;
      logic [7:0] code;
   } ps2_event_t;

   // True for bytes that only modify the next event instead of forming one
   function automatic logic is_prefix(input logic [7:0] b);
      return (b == PS2_EXT) || (b == PS2_REL);
   endfunction

endpackage
`default_nettype wire

// File: rtl/ps2_event_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : ps2_event_fifo
//  Description : Show-ahead event queue for decoded key events. The head
//                entry is always presented on o_rd_data (zero when empty).
//                A write while full succeeds only if a pop happens in the
//                same cycle; otherwise the caller sees o_full and drops it.
//  Revision    : 1.0 - initial release
// ============================================================================
module ps2_event_fifo
   import ps2_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       i_wr_en,
   input  ps2_event_t i_wr_data,
   input  logic       i_rd_en,
   output ps2_event_t o_rd_data,
   output logic       o_full,
   output logic       o_empty
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);
   localparam logic [CW-1:0] c_depth = CW'(DEPTH);

   ps2_event_t    r_mem [DEPTH];
   logic [AW-1:0] r_wr_ptr;
   logic [AW-1:0] r_rd_ptr;
   logic [CW-1:0] r_count;

   logic w_pop;
   logic w_push;

   assign o_empty = (r_count == '0);
   assign o_full  = (r_count == c_depth);
   assign w_pop   = i_rd_en & ~o_empty;
   // When full, a simultaneous pop frees the slot being written
   assign w_push  = i_wr_en & (~o_full | w_pop);

   // Head is forced to zero when empty so stale storage never leaks out
   assign o_rd_data = o_empty ? '0 : r_mem[r_rd_ptr];

   // Storage array, written on accepted pushes (no reset needed)
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= i_wr_data;
      end
   end

   // Pointers and occupancy; depth is a power of two so pointers wrap freely
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + AW'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + AW'(1);
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: rtl/ps2_kbd_rx.sv
`default_nettype none
// ============================================================================
//  Module      : ps2_kbd_rx
//  Description : PS/2 keyboard receiver front end. Synchronises and filters
//                the PS/2 clock, assembles 11-bit device-to-host frames,
//                checks start/parity/stop, folds E0/F0 prefixes into flags
//                and queues complete key events behind a valid/ready port.
//  Revision    : 1.0 - initial release
// ============================================================================
module ps2_kbd_rx
   import ps2_pkg::*;
#(
   parameter int FILTER_LEN     = 4,
   parameter int TIMEOUT_CYCLES = 50000,
   parameter int FIFO_DEPTH     = 4
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       ps2_kbd_clk,
   input  logic       ps2_kbd_data,
   output logic [7:0] code_out,
   output logic       code_ext,
   output logic       code_rel,
   output logic       code_valid,
   input  logic       code_ready,
   output logic       frame_err,
   output logic       overflow
);

   localparam int FW = $clog2(FILTER_LEN);
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [FW-1:0] c_filt_last = FW'(FILTER_LEN - 1);
   localparam logic [TW-1:0] c_to_max    = TW'(TIMEOUT_CYCLES);

   // Synchronisers
   logic r_clk_meta;
   logic r_clk_sync;
   logic r_dat_meta;
   logic r_dat_sync;

   // Clock filter
   logic          r_filt_clk;
   logic [FW-1:0] r_filt_cnt;
   logic          r_fall;

   // Frame receiver
   ps2_state_e    r_state;
   ps2_state_e    w_state_nxt;
   logic [2:0]    r_bit_cnt;
   logic [7:0]    r_shift;
   logic          r_par;
   logic [TW-1:0] r_to_cnt;

   logic w_bit_clr;
   logic w_shift_en;
   logic w_par_ld;
   logic w_timeout;
   logic w_start_err;
   logic w_frame_end;
   logic w_frame_good;

   // Prefix flags and staged FIFO write
   logic       r_ext_pend;
   logic       r_rel_pend;
   logic       r_frame_err;
   logic       r_wr_en;
   ps2_event_t r_wr_evt;

   // Queue interface
   ps2_event_t w_head;
   logic       w_full;
   logic       w_empty;
   logic       w_drop;

   // Two-flop synchronisers; idle-high reset matches an idle PS/2 bus
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_clk_meta <= 1'b1;
         r_clk_sync <= 1'b1;
         r_dat_meta <= 1'b1;
         r_dat_sync <= 1'b1;
      end else begin
         r_clk_meta <= ps2_kbd_clk;
         r_clk_sync <= r_clk_meta;
         r_dat_meta <= ps2_kbd_data;
         r_dat_sync <= r_dat_meta;
      end
   end

   // Filtered clock follows the sync'd pin after FILTER_LEN equal samples
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_filt_clk <= 1'b1;
         r_filt_cnt <= '0;
         r_fall     <= 1'b0;
      end else begin
         r_fall <= 1'b0;
         if (r_clk_sync == r_filt_clk) begin
            r_filt_cnt <= '0;
         end else if (r_filt_cnt == c_filt_last) begin
            r_filt_clk <= r_clk_sync;
            r_filt_cnt <= '0;
            r_fall     <= ~r_clk_sync;
         end else begin
            r_filt_cnt <= r_filt_cnt + FW'(1);
         end
      end
   end

   // Odd parity over data+parity and a high stop bit make a good frame
   assign w_frame_good = r_dat_sync & (^{r_shift, r_par});

   // Frame FSM state register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Frame FSM next state and datapath controls; timeout has priority
   always_comb begin
      w_state_nxt = r_state;
      w_bit_clr   = 1'b0;
      w_shift_en  = 1'b0;
      w_par_ld    = 1'b0;
      w_start_err = 1'b0;
      w_frame_end = 1'b0;
      w_timeout   = (r_state != ST_IDLE) && (r_to_cnt == c_to_max);
      if (w_timeout) begin
         w_state_nxt = ST_IDLE;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (r_fall) begin
                  if (!r_dat_sync) begin
                     w_state_nxt = ST_DATA;
                     w_bit_clr   = 1'b1;
                  end else begin
                     w_start_err = 1'b1;
                  end
               end
            end
            ST_DATA: begin
               if (r_fall) begin
                  w_shift_en = 1'b1;
                  if (r_bit_cnt == 3'd7) begin
                     w_state_nxt = ST_PARITY;
                  end
               end
            end
            ST_PARITY: begin
               if (r_fall) begin
                  w_par_ld    = 1'b1;
                  w_state_nxt = ST_STOP;
               end
            end
            ST_STOP: begin
               if (r_fall) begin
                  w_frame_end = 1'b1;
                  w_state_nxt = ST_IDLE;
               end
            end
            default: w_state_nxt = ST_IDLE;
         endcase
      end
   end

   // Bit counter, LSB-first shift register, parity latch, inter-edge timer
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_bit_cnt <= '0;
         r_shift   <= '0;
         r_par     <= 1'b0;
         r_to_cnt  <= '0;
      end else begin
         if (w_bit_clr) begin
            r_bit_cnt <= '0;
         end else if (w_shift_en) begin
            r_bit_cnt <= r_bit_cnt + 3'd1;
         end
         if (w_shift_en) begin
            r_shift <= {r_dat_sync, r_shift[7:1]};
         end
         if (w_par_ld) begin
            r_par <= r_dat_sync;
         end
         if ((r_state == ST_IDLE) || r_fall || w_timeout) begin
            r_to_cnt <= '0;
         end else begin
            r_to_cnt <= r_to_cnt + TW'(1);
         end
      end
   end

   // Frame outcome: error pulse, prefix flag tracking, staged event write
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_frame_err <= 1'b0;
         r_wr_en     <= 1'b0;
         r_wr_evt    <= '0;
         r_ext_pend  <= 1'b0;
         r_rel_pend  <= 1'b0;
      end else begin
         r_frame_err <= w_start_err | w_timeout | (w_frame_end & ~w_frame_good);
         r_wr_en     <= 1'b0;
         if (w_timeout || (w_frame_end && !w_frame_good) || w_drop) begin
            r_ext_pend <= 1'b0;
            r_rel_pend <= 1'b0;
         end else if (w_frame_end) begin
            if (r_shift == PS2_EXT) begin
               r_ext_pend <= 1'b1;
            end else if (r_shift == PS2_REL) begin
               r_rel_pend <= 1'b1;
            end else begin
               r_ext_pend <= 1'b0;
               r_rel_pend <= 1'b0;
            end
         end
         if (w_frame_end && w_frame_good && !is_prefix(r_shift)) begin
            r_wr_en       <= 1'b1;
            r_wr_evt.ext  <= r_ext_pend;
            r_wr_evt.rel  <= r_rel_pend;
            r_wr_evt.code <= r_shift;
         end
      end
   end

   // A staged write is lost only when full and the consumer is not popping
   assign w_drop = r_wr_en & w_full & ~(code_ready & ~w_empty);

   ps2_event_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .reset_n   (reset_n),
      .i_wr_en   (r_wr_en),
      .i_wr_data (r_wr_evt),
      .i_rd_en   (code_ready),
      .o_rd_data (w_head),
      .o_full    (w_full),
      .o_empty   (w_empty)
   );

   assign code_out   = w_head.code;
   assign code_ext   = w_head.ext;
   assign code_rel   = w_head.rel;
   assign code_valid = ~w_empty;
   assign frame_err  = r_frame_err;
   assign overflow   = w_drop;

endmodule
`default_nettype wire
